// File: rtl/result_stream_unit_if.sv
// rtl/result_stream_unit_if.sv - AXI-Stream bundle between result_stream_unit and the DMA
interface result_stream_unit_if #(
    parameter int DATA_W = 32
);
    logic                  M_AXIS_TVALID;
    logic [DATA_W-1:0]     M_AXIS_TDATA;
    logic [DATA_W/8-1:0]   M_AXIS_TSTRB;
    logic                  M_AXIS_TLAST;
    logic                  M_AXIS_TREADY;

    modport master (
        output M_AXIS_TVALID,
        output M_AXIS_TDATA,
        output M_AXIS_TSTRB,
        output M_AXIS_TLAST,
        input  M_AXIS_TREADY
    );

    modport slave (
        input  M_AXIS_TVALID,
        input  M_AXIS_TDATA,
        input  M_AXIS_TSTRB,
        input  M_AXIS_TLAST,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/result_stream_unit.sv
// rtl/result_stream_unit.sv - streams the result BRAM to the DMA (optional RESULT_STREAM_STALL_CNT_EN stall counter)
module result_stream_unit #(
    parameter int BRAM_DEPTH           = 10,
    parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              start,
    input  logic [BRAM_DEPTH:0]               length,
    output logic [BRAM_DEPTH-1:0]             res_addr,
    output logic                              res_en,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   res_dout,
    output logic                              busy,
    output logic                              done,
`ifdef RESULT_STREAM_STALL_CNT_EN
    output logic [31:0]                       stall_count,
`endif
    result_stream_unit_if.master              m_axis
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [BRAM_DEPTH:0] FULL_LEN = {1'b1, {BRAM_DEPTH{1'b0}}};
    localparam logic [BRAM_DEPTH:0] ONE      = {{BRAM_DEPTH{1'b0}}, 1'b1};

    state_t                            state_q, state_d;
    logic [BRAM_DEPTH:0]               len_q, len_d;
    logic [BRAM_DEPTH:0]               rd_ptr_q, rd_ptr_d;
    logic [BRAM_DEPTH:0]               beat_cnt_q, beat_cnt_d;
    logic                              rd_pend_q, rd_pend_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   buf_data_q [0:1];
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   buf_data_d [0:1];
    logic                              buf_head_q, buf_head_d;
    logic                              buf_tail_q, buf_tail_d;
    logic [1:0]                        occ_q, occ_d;
`ifdef RESULT_STREAM_STALL_CNT_EN
    logic [31:0]                       stall_q, stall_d;
`endif

    logic                              tvalid;
    logic                              tlast;
    logic                              pop;
    logic                              rd_issue;
    logic [2:0]                        fill;
    logic [BRAM_DEPTH:0]               len_sat;
    logic [BRAM_DEPTH:0]               len_m1;

    // Output decode, read-issue decision and length saturation
    always_comb begin
        tvalid   = (occ_q != 2'd0);
        pop      = tvalid & m_axis.M_AXIS_TREADY;
        len_m1   = len_q - ONE;
        tlast    = tvalid & (beat_cnt_q == len_m1);
        len_sat  = (length > FULL_LEN) ? FULL_LEN : length;
        // Count this cycle's pop as freed space so a steady stream never bubbles.
        fill     = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        rd_issue = (state_q == S_STREAM) && (rd_ptr_q < len_q) && (fill < 3'd2);
    end

    // Next-state logic for the FSM, pointers and the two-entry output buffer
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_ptr_d   = rd_ptr_q;
        beat_cnt_d = beat_cnt_q;
        rd_pend_d  = rd_issue;
        buf_data_d = buf_data_q;
        buf_head_d = buf_head_q;
        buf_tail_d = buf_tail_q;
        occ_d      = occ_q + {1'b0, rd_pend_q} - {1'b0, pop};
`ifdef RESULT_STREAM_STALL_CNT_EN
        stall_d    = stall_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = len_sat;
                    rd_ptr_d   = '0;
                    beat_cnt_d = '0;
`ifdef RESULT_STREAM_STALL_CNT_EN
                    stall_d    = '0;
`endif
                    state_d    = (len_sat == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (rd_issue) begin
                    rd_ptr_d = rd_ptr_q + ONE;
                end
                if (pop) begin
                    beat_cnt_d = beat_cnt_q + ONE;
                    if (tlast) begin
                        state_d = S_DONE;
                    end
                end
`ifdef RESULT_STREAM_STALL_CNT_EN
                if (tvalid && !m_axis.M_AXIS_TREADY && (stall_q != 32'hFFFF_FFFF)) begin
                    stall_d = stall_q + 32'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // BRAM data lands one cycle after its read was issued.
        if (rd_pend_q) begin
            buf_data_d[buf_tail_q] = res_dout;
            buf_tail_d             = ~buf_tail_q;
        end
        if (pop) begin
            buf_head_d = ~buf_head_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            rd_ptr_q   <= '0;
            beat_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            buf_data_q <= '{default: '0};
            buf_head_q <= 1'b0;
            buf_tail_q <= 1'b0;
            occ_q      <= 2'd0;
`ifdef RESULT_STREAM_STALL_CNT_EN
            stall_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            rd_pend_q  <= rd_pend_d;
            buf_data_q <= buf_data_d;
            buf_head_q <= buf_head_d;
            buf_tail_q <= buf_tail_d;
            occ_q      <= occ_d;
`ifdef RESULT_STREAM_STALL_CNT_EN
            stall_q    <= stall_d;
`endif
        end
    end

    assign res_en   = rd_issue;
    assign res_addr = rd_ptr_q[BRAM_DEPTH-1:0];
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

    assign m_axis.M_AXIS_TVALID = tvalid;
    assign m_axis.M_AXIS_TDATA  = buf_data_q[buf_head_q];
    assign m_axis.M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){1'b1}};
    assign m_axis.M_AXIS_TLAST  = tlast;

`ifdef RESULT_STREAM_STALL_CNT_EN
    assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_result_stream_unit.sv
// tb/tb_result_stream_unit.sv - self-checking bench for result_stream_unit
module tb_result_stream_unit;
    localparam int D = 10;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           aresetn;
    logic           start;
    logic [D:0]     length;
    logic [D-1:0]   res_addr;
    logic           res_en;
    logic [W-1:0]   res_dout;
    logic           busy;
    logic           done;
`ifdef RESULT_STREAM_STALL_CNT_EN
    logic [31:0]    stall_count;
`endif

    int total = 0;
    int bad   = 0;

    result_stream_unit_if #(.DATA_W(W)) axis ();

    result_stream_unit #(.BRAM_DEPTH(D), .C_M_AXIS_TDATA_WIDTH(W)) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (aresetn),
        .start          (start),
        .length         (length),
        .res_addr       (res_addr),
        .res_en         (res_en),
        .res_dout       (res_dout),
        .busy           (busy),
        .done           (done),
`ifdef RESULT_STREAM_STALL_CNT_EN
        .stall_count    (stall_count),
`endif
        .m_axis         (axis.master)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];

    always @(posedge clk) begin
        if (res_en === 1'b1) res_dout <= mem[res_addr];
    end

    typedef struct {
        int len;
        int fill;
        int rdy;
        int exp_beats;
        int exp_done;
        bit mid_start;
    } vec_t;

    vec_t tbl [8];
    int   pat [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic rdy_fn(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[(cyc - 1) % 8] != 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 1024; i++) begin
            case (mode)
                0:       mem[i] = i;
                2:       mem[i] = 32'hA0 + i;
                3:       mem[i] = (i == 0) ? 32'h55 : $urandom;
                default: mem[i] = $urandom;
            endcase
        end
    endtask

    task automatic run_xfer(input int len, input int fill, input int rdy,
                            input int exp_beats, input int exp_done, input bit mid);
        int          q[$];
        int          lsat;
        int          budget;
        int          issued = 0;
        int          beats = 0;
        int          stalls = 0;
        int          first_en = -1;
        int          first_v = -1;
        int          last_hs = -1;
        int          done_cyc = -1;
        bit          busy_ok = 1;
        bit          stable_ok = 1;
        bit          prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        int          expv;

        lsat = (len > 1024) ? 1024 : len;
        fill_mem(fill);
        for (int i = 0; i < lsat; i++) q.push_back(mem[i]);
        budget = lsat * 10 + 40;

        @(negedge clk);
        start = 1'b1;
        length = len[D:0];
        axis.M_AXIS_TREADY = 1'b1;
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int cyc = 1; cyc < budget; cyc++) begin
            @(negedge clk);
            start  = (mid && cyc == 10);
            length = (mid && cyc == 10) ? 11'd5 : len[D:0];
            axis.M_AXIS_TREADY = rdy_fn(rdy, cyc);
            #1;
            if (busy !== 1'b1) busy_ok = 0;
            if (res_en === 1'b1) begin
                if (first_en < 0) first_en = cyc;
                chk("rd_addr", {22'd0, res_addr}, issued);
                issued++;
            end
            if (prev_stall) begin
                if (axis.M_AXIS_TVALID !== 1'b1 || axis.M_AXIS_TDATA !== prev_data ||
                    axis.M_AXIS_TLAST !== prev_last) stable_ok = 0;
            end
            if (axis.M_AXIS_TVALID === 1'b1 && first_v < 0) first_v = cyc;
            if (axis.M_AXIS_TVALID === 1'b1 && axis.M_AXIS_TREADY) begin
                if (q.size() == 0) begin
                    chk("extra_beat", 32'd1, 32'd0);
                end else begin
                    expv = q.pop_front();
                    chk("tdata", axis.M_AXIS_TDATA, expv);
                    chk("tlast", {31'd0, axis.M_AXIS_TLAST}, {31'd0, q.size() == 0});
                end
                beats++;
                last_hs = cyc;
            end else if (axis.M_AXIS_TVALID === 1'b1) begin
                stalls++;
            end
            prev_stall = (axis.M_AXIS_TVALID === 1'b1) && !axis.M_AXIS_TREADY;
            prev_data  = axis.M_AXIS_TDATA;
            prev_last  = axis.M_AXIS_TLAST;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end

        chk("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
        chk("beats", beats, exp_beats);
        chk("reads_issued", issued, lsat);
        if (lsat > 0) chk("done_after_last", done_cyc, last_hs + 1);
        if (exp_done >= 0) chk("done_latency", done_cyc, exp_done);
        if (lsat > 0 && rdy == 0) begin
            chk("first_res_en", first_en, 1);
            chk("first_tvalid", first_v, 3);
        end
        if (lsat == 0) begin
            chk("no_res_en", first_en, -1);
            chk("no_tvalid", first_v, -1);
        end
        chk("busy_held", {31'd0, busy_ok}, 32'd1);
        chk("stall_stable", {31'd0, stable_ok}, 32'd1);
`ifdef RESULT_STREAM_STALL_CNT_EN
        chk("stall_count", stall_count, stalls);
`endif
        @(negedge clk);
        start = 1'b0;
        length = len[D:0];
        #1;
        chk("idle_after_busy", {31'd0, busy}, 32'd0);
        chk("idle_after_done", {31'd0, done}, 32'd0);
`ifdef RESULT_STREAM_STALL_CNT_EN
        chk("stall_count_hold", stall_count, stalls);
`endif
    endtask

    initial begin
        int beats;
        int rlen;
        bit quiet_ok;

        pat = '{1, 0, 0, 1, 0, 1, 1, 1};
        tbl[0] = '{4,    2, 0, 4,    7,    0};
        tbl[1] = '{0,    1, 0, 0,    1,    0};
        tbl[2] = '{1,    3, 0, 1,    4,    0};
        tbl[3] = '{8,    1, 1, 8,    -1,   0};
        tbl[4] = '{1024, 0, 0, 1024, 1027, 1};
        tbl[5] = '{2047, 1, 0, 1024, 1027, 0};
        tbl[6] = '{16,   1, 2, 16,   -1,   0};
        tbl[7] = '{1,    1, 1, 1,    -1,   0};

        aresetn = 1'b0;
        start = 1'b0;
        length = '0;
        axis.M_AXIS_TREADY = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
        chk("rst_tlast",  {31'd0, axis.M_AXIS_TLAST}, 32'd0);
        chk("rst_tdata",  axis.M_AXIS_TDATA, 32'd0);
        chk("rst_res_en", {31'd0, res_en}, 32'd0);
        chk("rst_addr",   {22'd0, res_addr}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("tstrb",      {28'd0, axis.M_AXIS_TSTRB}, 32'hF);
`ifdef RESULT_STREAM_STALL_CNT_EN
        chk("rst_stall",  stall_count, 32'd0);
`endif
        aresetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_xfer(tbl[i].len, tbl[i].fill, tbl[i].rdy, tbl[i].exp_beats,
                     tbl[i].exp_done, tbl[i].mid_start);
        end

        for (int r = 0; r < 6; r++) begin
            rlen = $urandom_range(1, 40);
            run_xfer(rlen, 1, 2, rlen, -1, 0);
        end

        // Reset while beat 5 of 16 is on the bus.
        fill_mem(1);
        @(negedge clk);
        start = 1'b1;
        length = 11'd16;
        axis.M_AXIS_TREADY = 1'b1;
        @(negedge clk);
        start = 1'b0;
        beats = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (axis.M_AXIS_TVALID === 1'b1 && beats == 5) break;
            if (axis.M_AXIS_TVALID === 1'b1) beats++;
            @(negedge clk);
        end
        chk("reached_beat5", beats, 5);
        aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        chk("mid_rst_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
        chk("mid_rst_busy",   {31'd0, busy}, 32'd0);
        chk("mid_rst_done",   {31'd0, done}, 32'd0);
        chk("mid_rst_res_en", {31'd0, res_en}, 32'd0);
        quiet_ok = 1;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0 || axis.M_AXIS_TVALID !== 1'b0 || busy !== 1'b0) quiet_ok = 0;
        end
        chk("no_resume", {31'd0, quiet_ok}, 32'd1);
        run_xfer(2, 1, 0, 2, 5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
